// File: rtl/dmem_arb_pkg.sv
// Shared constants and types for the dmem two-port arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package dmem_arb_pkg;

  // Requester identities
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  // Arbitration policies
  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  // Current lock owner of the memory port
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  // One slot of the read-return pipeline: is it a read, and who asked for it
  typedef struct packed {
    logic vld;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/dmem_arb_rdpipe.sv
// Read-return tag pipeline: tracks which port owns each outstanding read.
// Latency: DEPTH cycles from i_tag to o_tag.
// Backpressure: none; shifts every cycle and never stalls.
module dmem_arb_rdpipe
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clock,
  input  logic    reset,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag
);

  rd_tag_t r_pipe [DEPTH];

  // Shift one tag per cycle; reset discards every outstanding read
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_tag = r_pipe[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port dmem syncram (CPU = port 0, loader = port 1).
// Latency: grant and memory drive are combinational; read data returns READ_LATENCY cycles after grant.
// Backpressure: an ungranted requester simply keeps its request up; a lock holds ownership while req stays high.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,   // legal range 1..4
  parameter int PRIO_MODE    = 0    // 0 round-robin, 1 port 0 always wins
) (
  input  logic              clock,
  input  logic              reset,
  // port 0: processor
  input  logic              req0,
  input  logic              we0,
  input  logic              lock0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  // port 1: loader / debug
  input  logic              req1,
  input  logic              we1,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  // dmem side
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem
);

  localparam bit FIXED_PRIO = (PRIO_MODE == PRIO_FIXED);

  owner_e            r_owner;
  logic              r_last_winner;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  logic    w_gnt0;
  logic    w_gnt1;
  rd_tag_t w_push_tag;
  rd_tag_t w_pop_tag;

  // Grant decision: a locked owner keeps the port, otherwise arbitrate on the live requests.
  // Grants are forced low while reset is asserted so nothing reaches the memory.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (reset) begin
      if (r_owner == OWN_P0 && req0) begin
        w_gnt0 = 1'b1;
      end else if (r_owner == OWN_P1 && req1) begin
        w_gnt1 = 1'b1;
      end else if (req0 && req1) begin
        if (FIXED_PRIO) begin
          w_gnt0 = 1'b1;
        end else if (r_last_winner == PORT_CPU) begin
          w_gnt1 = 1'b1;
        end else begin
          w_gnt0 = 1'b1;
        end
      end else begin
        w_gnt0 = req0;
        w_gnt1 = req1;
      end
    end
  end

  // Memory-side mux: the winner drives the syncram; when idle the bus parks on the last access
  always_comb begin
    address_dmem = r_addr;
    data         = r_data;
    wren         = 1'b0;
    if (w_gnt0) begin
      address_dmem = addr0;
      data         = wdata0;
      wren         = we0;
    end else if (w_gnt1) begin
      address_dmem = addr1;
      data         = wdata1;
      wren         = we1;
    end
  end

  // Fairness history and parked bus values follow whichever port was granted
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_last_winner <= PORT_LDR;
      r_addr        <= '0;
      r_data        <= '0;
    end else if (w_gnt0) begin
      r_last_winner <= PORT_CPU;
      r_addr        <= addr0;
      r_data        <= wdata0;
    end else if (w_gnt1) begin
      r_last_winner <= PORT_LDR;
      r_addr        <= addr1;
      r_data        <= wdata1;
    end
  end

  // Ownership only survives while the owner keeps both req and lock high on a granted cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_owner <= OWN_NONE;
    end else if (w_gnt0 && lock0) begin
      r_owner <= OWN_P0;
    end else if (w_gnt1 && lock1) begin
      r_owner <= OWN_P1;
    end else begin
      r_owner <= OWN_NONE;
    end
  end

  // Tag each granted read with its port so the returning q_dmem can be steered
  always_comb begin
    w_push_tag.vld = (w_gnt0 && !we0) || (w_gnt1 && !we1);
    w_push_tag.id  = w_gnt1 ? PORT_LDR : PORT_CPU;
  end

  dmem_arb_rdpipe #(
    .DEPTH (READ_LATENCY)
  ) u_rdpipe (
    .clock (clock),
    .reset (reset),
    .i_tag (w_push_tag),
    .o_tag (w_pop_tag)
  );

  assign gnt0    = w_gnt0;
  assign gnt1    = w_gnt1;
  assign rvalid0 = w_pop_tag.vld && (w_pop_tag.id == PORT_CPU);
  assign rvalid1 = w_pop_tag.vld && (w_pop_tag.id == PORT_LDR);
  assign rdata0  = q_dmem;
  assign rdata1  = q_dmem;

endmodule
